scale_tick_divider: RTL
=======================

// Module: scale_tick_divider
// PURPOSE
//   Derives the slow waveform clock from sysclk using the 6-bit Scale word
//   produced by the frequency-adjust stage. Feeds the waveform summer: drives
//   Slow_clk (its Local_clk) and a one-cycle tick enable. Tick period is
//   PRESCALE*(Scale+1) sysclk cycles. Scale changes take effect only on a
//   period boundary, so no runt or stretched periods are ever produced.
// PARAMETERS
//   PRESCALE  1000  sysclk cycles per base unit; legal range 2..2^20
//   SCALE_W   6     width of Scale and scale_active
// PORTS
//   sysclk        in   1        system clock; all logic on its rising edge
//   reset         in   1        synchronous reset, active-low
//   enable        in   1        1 = run divider, 0 = stop and clear
//   Scale         in   SCALE_W  requested divide factor; period = PRESCALE*(Scale+1)
//   tick          out  1        one-sysclk-cycle pulse at each period end
//   Slow_clk      out  1        toggles on every tick; 50% duty, period 2*tick period
//   scale_active  out  SCALE_W  Scale value currently timing the period
//   update_ack    out  1        one-cycle pulse: pending Scale was just applied
// BEHAVIOUR
//   Reset (reset==0 at a sysclk edge): state=IDLE; tick=0, Slow_clk=0,
//     update_ack=0, scale_active=0; prescale count pc=0, unit count uc=0,
//     pending flag=0. Reset wins over every other event in the same cycle.
//   Counters: pc is $clog2(PRESCALE) bits, wraps PRESCALE-1 -> 0; uc is SCALE_W
//     bits, advances only when pc wraps, wraps scale_active -> 0. Unsigned only;
//     period uses Scale+1, so Scale=0 is legal (period = PRESCALE).
//   FSM:
//     IDLE: all counters held at 0; tick=0, Slow_clk=0. enable==1 -> LOAD.
//     LOAD: one cycle; scale_active<=Scale, pc<=0, uc<=0, pending<=0 -> RUN.
//       No update_ack is issued on LOAD.
//     RUN: counts. Terminal when pc==PRESCALE-1 && uc==scale_active: next edge
//       registers tick=1 for exactly one cycle, toggles Slow_clk, clears pc/uc.
//       enable==0 -> IDLE at the next edge, from any count. Slow_clk and tick go
//       to 0 in that same cycle; the partial period is discarded.
//   Latency: first tick is high in the cycle starting PRESCALE*(S+1)+1 edges
//     after the edge that entered LOAD (1 LOAD cycle + a full period). Each
//     later tick follows the previous one by exactly PRESCALE*(S+1) cycles.
//   Scale update: in RUN, Scale != scale_active sets pending. At the terminal
//     edge with pending==1: scale_active<=Scale (value sampled at that edge),
//     pending<=0, update_ack=1 for one cycle, aligned with tick.
//     Scale toggling and returning to scale_active before the boundary: the
//     update still fires; it reloads the same value and pulses update_ack.
//   Simultaneous events: enable fall at a terminal edge -> IDLE wins; no tick
//     and no update_ack. reset mid-period -> immediate clear, no partial tick.
//   Scale is sampled only in LOAD and at terminal edges; it is assumed stable
//     (debounced, synchronous to sysclk) from the adjust stage.
// TESTING (PRESCALE=4 for simulation)
//   Scale=0, enable=1 -> tick every 4 cycles; Slow_clk period 8, 50% duty.
//   Scale=3 -> tick spacing 16; first tick 17 cycles after enable is sampled.
//   Scale=3 running, set Scale=1 at cycle 5 of a period -> that period ends at
//     16, then spacing 8; update_ack coincides with the boundary tick.
//   Scale=63 -> spacing 256; uc wraps 63 -> 0 without overflow.
//   enable drops 0 mid-period -> tick=0 and Slow_clk=0 next cycle; re-enable
//     -> LOAD then a full 4*(S+1) period.
//   reset=0 held 2 cycles mid-RUN -> all outputs 0, scale_active=0; recovers
//     via IDLE -> LOAD.

Source files
------------

// File: rtl/scale_tick_divider.sv
// Slow waveform clock generator: divides sysclk by PRESCALE*(Scale+1), emitting
// a one-cycle tick per period and a 50% Slow_clk; Scale changes apply on boundaries.
module scale_tick_divider #(
  parameter int PRESCALE = 1000,
  parameter int SCALE_W  = 6
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               enable,
  input  logic [SCALE_W-1:0] Scale,
  output logic               tick,
  output logic               Slow_clk,
  output logic [SCALE_W-1:0] scale_active,
  output logic               update_ack
);

  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [SCALE_W-1:0] uc_q, uc_d;
  logic [SCALE_W-1:0] sa_q, sa_d;
  logic               pending_q, pending_d;
  logic               tick_q, tick_d;
  logic               slow_q, slow_d;
  logic               ack_q, ack_d;
  logic               pc_wrap;
  logic               terminal;

  assign pc_wrap  = (pc_q == PC_LAST);
  assign terminal = pc_wrap && (uc_q == sa_q);

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      uc_q      <= '0;
      sa_q      <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      slow_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      uc_q      <= uc_d;
      sa_q      <= sa_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      slow_q    <= slow_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    uc_d      = uc_q;
    sa_d      = sa_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
    slow_d    = slow_q;
    ack_d     = 1'b0;

    case (state_q)
      IDLE: begin
        pc_d      = '0;
        uc_d      = '0;
        slow_d    = 1'b0;
        pending_d = 1'b0;
        if (enable) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        sa_d      = Scale;
        pc_d      = '0;
        uc_d      = '0;
        pending_d = 1'b0;
        slow_d    = 1'b0;
        state_d   = enable ? RUN : IDLE;
      end

      RUN: begin
        if (!enable) begin
          // Partial period is dropped; outputs return low immediately.
          state_d   = IDLE;
          pc_d      = '0;
          uc_d      = '0;
          slow_d    = 1'b0;
          pending_d = 1'b0;
        end else if (terminal) begin
          tick_d = 1'b1;
          slow_d = ~slow_q;
          pc_d   = '0;
          uc_d   = '0;
          if (pending_q) begin
            sa_d      = Scale;
            pending_d = 1'b0;
            ack_d     = 1'b1;
          end else if (Scale != sa_q) begin
            pending_d = 1'b1;
          end
        end else begin
          pc_d = pc_wrap ? '0 : pc_q + PC_W'(1);
          if (pc_wrap) begin
            uc_d = uc_q + SCALE_W'(1);
          end
          if (Scale != sa_q) begin
            pending_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tick         = tick_q;
  assign Slow_clk     = slow_q;
  assign scale_active = sa_q;
  assign update_ack   = ack_q;

endmodule
